input_debounce_bank: RTL and testbench
======================================

# input_debounce_bank

Parametrised bank of independent switch/button conditioners placed between the board's raw input pins and all consuming logic. Each channel synchronises its asynchronous pin, filters bounce with a per-channel stability counter, and provides a clean level, single-cycle rise/fall pulses, and a sticky change flag. It generalises the fixed 24-switch debounce array to any channel count, filter length and synchroniser depth, and adds edge and change reporting.

## Interface
Parameters:
- `N`, 24: number of channels.
- `DB_CYCLES`, 2_000_000: cycles a new level must persist before acceptance (20 ms at 100 MHz); must be ≥1.
- `SYNC_STAGES`, 2: synchroniser flops per channel; must be ≥2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-low reset.
- `raw`  in  N  asynchronous pin inputs.
- `level`  out  N  debounced level per channel.
- `rise`  out  N  one-cycle pulse when `level` goes 0→1.
- `fall`  out  N  one-cycle pulse when `level` goes 1→0.
- `changed`  out  N  sticky per-channel flag, set by any rise or fall.
- `clr`  in  N  per-channel clear of `changed`.
- `any_change`  out  1  OR of `rise | fall` this cycle.

## Operation
- Per channel: `SYNC_STAGES`-deep flop chain on `raw[i]`; last stage is `s[i]`.
- Counter `cnt[i]`, width `max(1, $clog2(DB_CYCLES))`.
- Each edge, per channel:
  - `s == level`: `cnt` ← 0.
  - `s != level` and `cnt < DB_CYCLES-1`: `cnt` ← `cnt+1`.
  - `s != level` and `cnt == DB_CYCLES-1`: `level` ← `s`, `cnt` ← 0, and `rise` or `fall` asserted for exactly that cycle, matching the new level.
- Any return of `s` to `level` before acceptance discards the count. Glitches shorter than `DB_CYCLES` cycles never reach `level`.
- `DB_CYCLES == 1`: a level is accepted on the first edge where `s != level`.
- `changed[i]` is set by `rise[i] | fall[i]` and cleared by `clr[i]`. If set and clear occur in the same cycle, set wins.
- `any_change` is registered from the same-cycle `rise | fall`, so it is asserted in the same cycle as those pulses.
- Channels are fully independent; simultaneous events on several channels are all reported.

## Timing
- Reset (`rst == 0` at an edge) clears all synchroniser flops, `level`, `cnt`, `rise`, `fall`, `changed` and `any_change` to 0.
- Reset mid-count abandons the count.
- A channel whose pin is high through reset produces a `rise` pulse `SYNC_STAGES + DB_CYCLES` edges after reset release. This is intended: consumers see the initial state as an event.
- Latency: a clean step on `raw` sampled at edge 0 appears on `level`, `rise`/`fall` and `any_change` after edge `SYNC_STAGES + DB_CYCLES - 1`, i.e. `SYNC_STAGES + DB_CYCLES` edges total.
- `changed` sets one edge later than the pulse.
- All outputs are registered; no combinational path from `raw` or `clr` to any output.
- Pulses are never wider than one cycle. Minimum spacing between two same-direction pulses on one channel is `2*DB_CYCLES` cycles.

## Structure
- Shared package `input_pkg` holds the default constants:
  - `CLK_HZ`
  - `DB_MS`
  - derived `DB_CYCLES_DEFAULT`
  - `SYNC_STAGES_DEFAULT`
- Other input blocks use the same package.
- One sub-module, `debounce_channel`, covers one channel: synchroniser, counter, level, rise/fall and the changed bit. It is instantiated `N` times via generate.
- The top level adds only the `any_change` reduction register.
- Parameter legality (`DB_CYCLES ≥ 1`, `SYNC_STAGES ≥ 2`) is checked at elaboration.

## Test plan
All scenarios use `N=4`, `DB_CYCLES=4`, `SYNC_STAGES=2` unless stated.
- **Clean press/release:** `raw[0]` 0→1 held 10 cycles, then 1→0.
  - `level[0]` rises 6 edges after the first sampling edge, with a 1-cycle `rise[0]` and `any_change`; `changed[0]` is set on the next edge.
  - Release mirrors this with `fall[0]`.
- **Glitch rejection:** `raw[1]` high for 3 cycles, then low.
  - `level[1]`, `rise`, `fall` and `changed` stay 0 throughout.
- **Bounce:** `raw[2]` toggles 1,0,1,0,1 on successive cycles, then holds 1.
  - Exactly one `rise[2]`, 6 edges after the final transition to 1; no `fall`.
- **Reset mid-count:** `raw[3]` goes high; `rst=0` for one cycle during counting; `raw[3]` stays high.
  - All outputs are 0 after the reset edge.
  - `rise[3]` occurs 6 edges after reset release.
- **Sticky clear collision:** `clr[0]=1` held across the edge where `changed[0]` would set.
  - `changed[0]` is 1 (set wins).
  - `clr[0]=1` on the next cycle with no event gives `changed[0]` 0.
- **Independence and boundary:** simultaneous clean steps on all 4 channels.
  - `rise = 4'hF` in a single cycle.
  - Rerun with `DB_CYCLES=1`: latency of 3 edges.

Source files
------------

// File: rtl/input_pkg.sv
// Shared constants and helpers for the board input conditioning blocks.
// The defaults target a 100 MHz clock with a 20 ms debounce window.
package input_pkg;

  localparam int CLK_HZ              = 100_000_000;
  localparam int DB_MS               = 20;
  localparam int DB_CYCLES_DEFAULT   = (CLK_HZ / 1000) * DB_MS;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10
  } edge_e;

  // Stability counter width; a single-cycle filter still needs one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: synchroniser chain, stability counter, accepted level,
// registered rise/fall pulses and a sticky change flag.
module debounce_channel
  import input_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  input  logic clr_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic changed_o,
  output logic pulse_next_o
);

  localparam int            CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_d;
  logic                   level_q;
  logic                   level_d;
  logic                   rise_q;
  logic                   fall_q;
  logic                   changed_q;
  logic                   changed_d;
  edge_e                  edge_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Any cycle where the synchronised pin agrees with the level restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    edge_d  = EDGE_NONE;
    if (s != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = s;
        edge_d  = s ? EDGE_RISE : EDGE_FALL;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // A pulse seen this cycle outranks a simultaneous clear.
  assign changed_d = rise_q | fall_q | (changed_q & ~clr_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= (edge_d == EDGE_RISE);
      fall_q    <= (edge_d == EDGE_FALL);
      changed_q <= changed_d;
    end
  end

  assign level_o      = level_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign changed_o    = changed_q;
  assign pulse_next_o = (edge_d != EDGE_NONE);

endmodule

// File: rtl/input_debounce_bank.sv
// Bank of N independent debounced inputs plus a registered "something changed
// this cycle" summary that lines up with the per-channel pulses.
module input_debounce_bank
  import input_pkg::*;
#(
  parameter int N           = 24,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] changed,
  input  logic [N-1:0] clr,
  output logic         any_change
);

  if (DB_CYCLES < 1) begin : g_bad_db_cycles
    $error("input_debounce_bank: DB_CYCLES must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("input_debounce_bank: SYNC_STAGES must be >= 2");
  end

  logic [N-1:0] pulse_next;
  logic         any_change_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_chan
    debounce_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .raw_i        (raw[gi]),
      .clr_i        (clr[gi]),
      .level_o      (level[gi]),
      .rise_o       (rise[gi]),
      .fall_o       (fall[gi]),
      .changed_o    (changed[gi]),
      .pulse_next_o (pulse_next[gi])
    );
  end

  // Registered from the channels' next-state pulses so it coincides with rise/fall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      any_change_q <= 1'b0;
    end else begin
      any_change_q <= |pulse_next;
    end
  end

  assign any_change = any_change_q;

endmodule

// File: tb/tb_input_debounce_bank.sv
// Scoreboard bench: two banks (DB_CYCLES=4 and DB_CYCLES=1) driven with the same
// stimulus and compared every cycle against a window-based reference model.
module tb_input_debounce_bank;

  localparam int N    = 4;
  localparam int SYNC = 2;

  typedef struct packed {
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] changed;
    logic       any;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw;
  logic [3:0] clr;

  logic [3:0] level4, rise4, fall4, changed4;
  logic       any4;
  logic [3:0] level1, rise1, fall1, changed1;
  logic       any1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail_prints = 0;

  always #5 clk = ~clk;

  input_debounce_bank #(.N(N), .DB_CYCLES(4), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .rst(rst), .raw(raw), .level(level4), .rise(rise4), .fall(fall4),
    .changed(changed4), .clr(clr), .any_change(any4)
  );

  input_debounce_bank #(.N(N), .DB_CYCLES(1), .SYNC_STAGES(SYNC)) dut1 (
    .clk(clk), .rst(rst), .raw(raw), .level(level1), .rise(rise1), .fall(fall1),
    .changed(changed1), .clr(clr), .any_change(any1)
  );

  // ---------------- reference model ----------------
  // A level is accepted once the synchronised pin has shown the opposite value
  // on each of the last DB edges since reset.
  int         db_of[2] = '{4, 1};
  bit         rawh[4][$];
  bit         shist[2][4][$];
  bit   [3:0] m_level[2];
  bit   [3:0] m_rise[2];
  bit   [3:0] m_fall[2];
  bit   [3:0] m_changed[2];
  obs_t       expq[2][$];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_level[k] = '0; m_rise[k] = '0; m_fall[k] = '0; m_changed[k] = '0;
        for (int ch = 0; ch < N; ch++) shist[k][ch].delete();
      end else begin
        bit [3:0] prev_pulse;
        prev_pulse   = m_rise[k] | m_fall[k];
        m_changed[k] = prev_pulse | (m_changed[k] & ~clr);
        m_rise[k]    = '0;
        m_fall[k]    = '0;
        for (int ch = 0; ch < N; ch++) begin
          bit s;
          bit stable;
          int sz;
          s = (rawh[ch].size() >= SYNC) ? rawh[ch][rawh[ch].size() - SYNC] : 1'b0;
          shist[k][ch].push_back(s);
          if (shist[k][ch].size() > 8) void'(shist[k][ch].pop_front());
          sz = shist[k][ch].size();
          if (sz >= db_of[k]) begin
            stable = 1'b1;
            for (int j = 1; j <= db_of[k]; j++)
              if (shist[k][ch][sz - j] == m_level[k][ch]) stable = 1'b0;
            if (stable) begin
              m_level[k][ch] = ~m_level[k][ch];
              if (m_level[k][ch]) m_rise[k][ch] = 1'b1;
              else                m_fall[k][ch] = 1'b1;
            end
          end
        end
      end
      expq[k].push_back('{level: m_level[k], rise: m_rise[k], fall: m_fall[k],
                          changed: m_changed[k], any: |(m_rise[k] | m_fall[k])});
    end
    for (int ch = 0; ch < N; ch++) begin
      if (!rst) rawh[ch].delete();
      else begin
        rawh[ch].push_back(raw[ch]);
        if (rawh[ch].size() > 8) void'(rawh[ch].pop_front());
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    obs_t act, exp_v;
    if (expq[0].size() > 0) begin
      exp_v = expq[0].pop_front();
      act   = '{level: level4, rise: rise4, fall: fall4, changed: changed4, any: any4};
      n_checks++;
      if (act === exp_v) n_pass++;
      else if (n_fail_prints++ < 30)
        $display("FAIL db4_cycle t=%0t actual=%h required=%h (level,rise,fall,changed,any)",
                 $time, act, exp_v);
    end
    if (expq[1].size() > 0) begin
      exp_v = expq[1].pop_front();
      act   = '{level: level1, rise: rise1, fall: fall1, changed: changed1, any: any1};
      n_checks++;
      if (act === exp_v) n_pass++;
      else if (n_fail_prints++ < 30)
        $display("FAIL db1_cycle t=%0t actual=%h required=%h (level,rise,fall,changed,any)",
                 $time, act, exp_v);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, req);
  endtask

  // Counts edges from the next one (edge 1) until the pulse appears; -1 = none.
  task automatic measure(input int ch, input bit want_rise, input string nm,
                         input int req4, input int req1);
    int l4 = -1;
    int l1 = -1;
    for (int n = 1; n <= 40 && (l4 < 0 || l1 < 0); n++) begin
      @(posedge clk); #1;
      if (l4 < 0 && (want_rise ? rise4[ch] : fall4[ch])) l4 = n;
      if (l1 < 0 && (want_rise ? rise1[ch] : fall1[ch])) l1 = n;
    end
    check({nm, "_latency_db4"}, l4, req4);
    if (req1 >= 0) check({nm, "_latency_db1"}, l1, req1);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst = 1'b0; raw = '0; clr = '0;
    idle(2);
    rst = 1'b1;
    idle(10);
    $display("scenario reset: done");

    raw[0] = 1'b1;
    measure(0, 1'b1, "press", 6, 3);
    idle(5);
    raw[0] = 1'b0;
    measure(0, 1'b0, "release", 6, 3);
    idle(8);
    $display("scenario clean press/release: done");

    raw[1] = 1'b1;
    idle(3);
    raw[1] = 1'b0;
    idle(10);
    check("glitch_level_db4", int'(level4[1]), 0);
    check("glitch_changed_db4", int'(changed4[1]), 0);
    $display("scenario glitch: done");

    raw[2] = 1'b1; idle(1);
    raw[2] = 1'b0; idle(1);
    raw[2] = 1'b1; idle(1);
    raw[2] = 1'b0; idle(1);
    raw[2] = 1'b1;
    measure(2, 1'b1, "bounce", 6, -1);
    idle(10);
    $display("scenario bounce: done");

    raw[3] = 1'b1;
    idle(3);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_outputs_db4", int'({level4, rise4, fall4, changed4, any4}), 0);
    @(negedge clk);
    rst = 1'b1;
    measure(3, 1'b1, "reset_release", 6, 3);
    idle(8);
    $display("scenario reset mid-count: done");

    clr = 4'hF; idle(1);
    clr = 4'b0001;
    raw[0] = 1'b1;
    measure(0, 1'b1, "sticky_press", 6, 3);
    @(posedge clk); #1;
    check("sticky_set_wins", int'(changed4[0]), 1);
    @(posedge clk); #1;
    check("sticky_clear", int'(changed4[0]), 0);
    @(negedge clk);
    clr = '0;
    idle(4);
    $display("scenario sticky clear collision: done");

    raw = '0;
    idle(12);
    clr = 4'hF; idle(1); clr = '0;
    raw = 4'hF;
    lat = -1;
    for (int n = 1; n <= 20 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (rise4 != 4'h0) begin
        lat = n;
        check("simultaneous_rise_db4", int'(rise4), 15);
      end
    end
    check("simultaneous_latency_db4", lat, 6);
    @(negedge clk);
    idle(8);
    $display("scenario simultaneous steps: done");

    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 5) == 0) raw[ch] = ~raw[ch];
      for (int ch = 0; ch < N; ch++)
        clr[ch] = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 299) != 0);
      idle(1);
    end
    rst = 1'b1; clr = '0;
    idle(20);
    $display("scenario random: done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
